ray_sphere_intersect_seq: RTL
=============================

// Module: ray_sphere_intersect_seq
// PURPOSE
//  Multi-cycle ray/sphere intersector for the ray tracer. Accepts one ray plus sphere per handshake and solves
//  |e + t*d - c|^2 = r^2 with a shared datapath, iterative sqrt and iterative divide. Returns the nearest
//  non-negative integer hit distance t, a hit flag and the sphere colour. Sits between ray generation and the
//  nearest-object compare stage; replaces the combinational, fixed-width sphere tracer.
// PARAMETERS
//  COORD_W  10  signed width of each coordinate/direction component (x,y,z)
//  R_W       8  unsigned radius width
//  COLOR_W  12  colour width, passed through unchanged
//  T_W      10  unsigned width of t_out; T_MAX = 2^T_W-1
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active low
//  in_valid   in   1              request valid
//  in_ready   out  1              block can accept a request
//  init       in   3*COORD_W      ray origin e = {ex,ey,ez}, ex in MSBs, signed
//  dir        in   3*COORD_W      ray direction d = {dx,dy,dz}, signed, must be non-zero
//  object_in  in   COLOR_W+R_W+3*COORD_W  {color, r, cx, cy, cz}
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts result
//  hit        out  1              ray hits sphere at t >= 0
//  t_out      out  T_W            hit distance; T_MAX on miss
//  color_out  out  COLOR_W        colour of the sphere of this request
// BEHAVIOUR
//  - Clock clk, reset rst_n: one clock; reset is synchronous and active-low. In a reset cycle: state=IDLE,
//    in_ready=0, out_valid=0, hit=0, t_out=T_MAX, color_out=0; in-flight job discarded, no output for it.
//  - Arithmetic signed two's complement, sign-extended; internal D_W = 4*COORD_W+8 bits, no overflow possible.
//    oc = e-c; a = d.d; b = d.oc (half-b); k = oc.oc - r^2; disc = b^2 - a*k.
//  - FSM: IDLE -> DOT -> DISC -> SQRT -> DIV -> DONE -> IDLE.
//    IDLE: in_ready=1; on in_valid&&in_ready capture init/dir/object_in, go DOT. in_ready=0 outside IDLE.
//    DOT (1 cyc): register oc, a, b, k.  DISC (1 cyc): register disc, negative flag.
//    SQRT (D_W/2 cyc): restoring integer sqrt, s = floor(sqrt(disc)); runs on 0 if disc<0.
//    DIV (T_W cyc): n = -b - s; if n<0 use n = -b + s. Both <0 or disc<0 -> miss. Pre-check: n >= a<<T_W
//      -> saturate t=T_MAX with hit=1. Else restoring divide, t = floor(n/a).
//    DONE: out_valid=1, outputs stable until out_valid&&out_ready, then IDLE (in_ready=1 next cycle).
//  - Latency (feature off): out_valid rises exactly 2+D_W/2+T_W cycles after the accept cycle
//    (default 36); throughput one request per latency+2 cycles with out_ready held 1.
//  - Miss: hit=0, t_out=T_MAX. Tangent (disc=0): hit, t=-b/a if >=0.
//  - out_ready is ignored outside DONE; in_valid ignored outside IDLE (no buffering, no drop of accepted job).
//  - Outputs are registered; hit/t_out/color_out change only on entry to DONE.
// CONFIGURATION
//  RAY_SPHERE_EARLY_REJECT_EN defined: when disc<0 in DISC, jump straight to DONE with miss; latency for misses
//    becomes 2 cycles; hits unchanged.
//  Not defined: every request takes the fixed latency above regardless of outcome (deterministic scheduling).
// TESTING (defaults unless stated)
//  1 e=(0,0,0) d=(0,0,1) c=(0,0,100) r=10 color=12'hABC -> disc=100, hit=1 t_out=90 color_out=ABC at 36 cyc.
//  2 same ray, c=(50,0,100) r=10 -> hit=0 t_out=1023; 36 cyc off, 2 cyc with RAY_SPHERE_EARLY_REJECT_EN.
//  3 origin inside: e=(0,0,100) d=(0,0,1) c=(0,0,100) r=10 -> near=-10 rejected, hit=1 t_out=10.
//  4 behind: e=0 d=(0,0,1) c=(0,0,-100) r=10 -> both roots <0, hit=0 t_out=1023; T_W=8, e=(0,0,-500)
//    c=(0,0,500) r=5 -> hit=1 t_out=255 (saturated from 995).
//  5 backpressure: out_ready=0 for 20 cyc in DONE -> outputs stable, in_ready=0, new in_valid not accepted;
//    out_ready=1 -> out_valid drops next cycle, in_ready=1.
//  6 rst_n=0 for 1 cyc mid-SQRT -> all outputs at reset values next cycle, no result for that job; next
//    request (test 1) returns t_out=90 with normal latency.

Source files
------------

// File: rtl/ray_sphere_intersect_seq.sv
// Multi-cycle ray/sphere intersector: shared dot-product datapath, iterative sqrt and divide.
// Define RAY_SPHERE_EARLY_REJECT_EN to retire negative-discriminant rays straight from DISC.
module ray_sphere_intersect_seq #(
    parameter int COORD_W = 10,
    parameter int R_W     = 8,
    parameter int COLOR_W = 12,
    parameter int T_W     = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [3*COORD_W-1:0]             init,
    input  logic [3*COORD_W-1:0]             dir,
    input  logic [COLOR_W+R_W+3*COORD_W-1:0] object_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             hit,
    output logic [T_W-1:0]                   t_out,
    output logic [COLOR_W-1:0]               color_out
);
    localparam int D_W   = 4*COORD_W + 8;
    localparam int S_W   = D_W / 2;
    localparam int CNT_W = $clog2((S_W > T_W ? S_W : T_W) + 1);
    localparam logic [T_W-1:0] T_MAX = '1;

    typedef enum logic [2:0] {IDLE, DOT, DISC, SQRT, DIV, DONE} state_t;
    state_t state;

    logic [3*COORD_W-1:0] e_q, d_q, c_q;
    logic [R_W-1:0] r_q;
    logic [COLOR_W-1:0] color_q;
    logic signed [D_W-1:0] a_q, b_q, k_q;
    logic neg_q, miss_q, sat_q;
    logic [D_W-1:0] rad_q, rem_q;
    logic [S_W-1:0] root_q;
    logic signed [D_W-1:0] drem_q, dvs_q;
    logic [T_W-1:0] quo_q;
    logic [CNT_W-1:0] cnt;

    function automatic logic signed [D_W-1:0] sx(input logic [COORD_W-1:0] v);
        return {{(D_W-COORD_W){v[COORD_W-1]}}, v};
    endfunction

    logic signed [D_W-1:0] dx, dy, dz, ox, oy, oz, rr, disc;
    assign dx = sx(d_q[3*COORD_W-1 -: COORD_W]);
    assign dy = sx(d_q[2*COORD_W-1 -: COORD_W]);
    assign dz = sx(d_q[COORD_W-1:0]);
    assign ox = sx(e_q[3*COORD_W-1 -: COORD_W]) - sx(c_q[3*COORD_W-1 -: COORD_W]);
    assign oy = sx(e_q[2*COORD_W-1 -: COORD_W]) - sx(c_q[2*COORD_W-1 -: COORD_W]);
    assign oz = sx(e_q[COORD_W-1:0]) - sx(c_q[COORD_W-1:0]);
    assign rr = {{(D_W-R_W){1'b0}}, r_q};
    assign disc = b_q * b_q - a_q * k_q;

    // One restoring-sqrt step: two radicand bits per cycle
    logic [D_W-1:0] rem_sh, trial, rem_n;
    logic ge;
    assign rem_sh = (rem_q << 2) | D_W'(rad_q[D_W-1 -: 2]);
    assign trial  = {{(D_W-S_W-2){1'b0}}, root_q, 2'b01};
    assign ge     = rem_sh >= trial;
    assign rem_n  = ge ? rem_sh - trial : rem_sh;

    logic signed [D_W-1:0] s_ext, n_near, n_far, n0, n_cur, n_sub;
    logic first, miss0, sat0, miss_f, sat_f, qbit;
    logic [T_W-1:0] quo_n;
    assign s_ext  = {{(D_W-S_W){1'b0}}, root_q};
    assign n_near = -b_q - s_ext;
    assign n_far  = -b_q + s_ext;
    assign n0     = n_near[D_W-1] ? n_far : n_near;
    assign miss0  = neg_q | n_far[D_W-1];
    assign sat0   = n0 >= (a_q <<< T_W);
    assign first  = cnt == '0;
    assign miss_f = first ? miss0 : miss_q;
    assign sat_f  = first ? sat0 : sat_q;
    assign n_cur  = first ? n0 : drem_q;
    assign qbit   = n_cur >= dvs_q;
    assign n_sub  = qbit ? n_cur - dvs_q : n_cur;
    assign quo_n  = (quo_q << 1) | T_W'(qbit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            hit       <= 1'b0;
            t_out     <= T_MAX;
            color_out <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        state    <= DOT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DOT: begin
                    cnt   <= '0;
                    state <= DISC;
                end
                DISC: begin
`ifdef RAY_SPHERE_EARLY_REJECT_EN
                    if (disc[D_W-1]) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        hit       <= 1'b0;
                        t_out     <= T_MAX;
                        color_out <= color_q;
                    end else begin
                        state <= SQRT;
                    end
`else
                    state <= SQRT;
`endif
                end
                SQRT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(S_W-1)) begin
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(T_W-1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        hit       <= !miss_f;
                        t_out     <= (miss_f || sat_f) ? T_MAX : quo_n;
                        color_out <= color_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && in_ready) begin
            e_q     <= init;
            d_q     <= dir;
            c_q     <= object_in[3*COORD_W-1:0];
            r_q     <= object_in[3*COORD_W +: R_W];
            color_q <= object_in[3*COORD_W+R_W +: COLOR_W];
        end
        if (state == DOT) begin
            a_q <= dx*dx + dy*dy + dz*dz;
            b_q <= dx*ox + dy*oy + dz*oz;
            k_q <= ox*ox + oy*oy + oz*oz - rr*rr;
        end
        if (state == DISC) begin
            neg_q  <= disc[D_W-1];
            rad_q  <= disc[D_W-1] ? '0 : disc;
            rem_q  <= '0;
            root_q <= '0;
        end
        if (state == SQRT) begin
            rad_q  <= rad_q << 2;
            rem_q  <= rem_n;
            root_q <= (root_q << 1) | S_W'(ge);
            dvs_q  <= a_q <<< (T_W-1);
        end
        if (state == DIV) begin
            drem_q <= n_sub;
            quo_q  <= quo_n;
            dvs_q  <= dvs_q >>> 1;
            if (first) begin
                miss_q <= miss0;
                sat_q  <= sat0;
            end
        end
    end
endmodule
